jt6295_nibble_fetch: RTL
========================

Name: jt6295_nibble_fetch

Overview:
- Upstream feeder for the ADPCM decoder: for 4 time-multiplexed voice channels, reads sample bytes from ADPCM ROM and delivers one 4-bit nibble per active channel slot.
- Outputs (data, en, slot) connect directly to the decoder's data/en inputs, in slot order 0,1,2,3.
- Command side (phrase start/stop) comes from the host register decoder; ROM side is a single shared, variable-latency byte port.

Parameters:
AW, 18, ROM byte address width.
NCH, 4, channel count (fixed at 4; slot counter is 2 bits).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
cen  in  1  clock enable; each cen advances the slot counter by one
start  in  1  start strobe for channel start_ch (one clk)
start_ch  in  2  channel index for start
start_addr  in  AW  first byte address (inclusive)
stop_addr  in  AW  last byte address (inclusive)
stop  in  4  per-channel stop mask strobe (one clk)
rom_addr  out  AW  ROM byte address
rom_cs  out  1  ROM request; held high until rom_ok
rom_data  in  8  ROM byte, valid when rom_ok
rom_ok  in  1  ROM acknowledge, one clk
data  out  4  nibble for the current slot
en  out  1  one-clk pulse: data valid for decoder slot `slot`
slot  out  2  channel index of data/en
busy  out  4  per-channel playing flag
done  out  4  one-clk pulse when a channel plays its final nibble
underrun  out  4  sticky flag: slot arrived with an empty buffer; cleared by start on that channel

Behaviour:
- Reset (async, rst_n=0): all outputs 0; slot counter 0; all busy, buffer-valid and pointer state cleared; any outstanding ROM request is dropped.
- Per-channel state: nibble pointer {byte addr[AW-1:0], hi/lo sel}, stop addr, 8-bit byte buffer, buf_valid, busy.
- Start: busy<=1, pointer<=start_addr (high nibble first), buf_valid<=0, underrun<=0. A start on a busy channel restarts it. If a fetch for that channel is outstanding, its result is discarded (tagged request).
- Stop: busy<=0 and buf_valid<=0 for each masked channel; any outstanding fetch result for that channel is discarded; no done pulse.
- Start and stop on the same channel in the same clk: start wins.
- Slot service, on each cen for slot s:
  - If busy[s] and buf_valid[s]: registered output on the next clk with data = selected nibble (high nibble when sel=0), en=1, slot=s. sel toggles.
  - After the low nibble: buf_valid<=0 and the byte address increments (wraps 2^AW-1 -> 0).
  - If the played byte address equals stop_addr and the low nibble was just played: busy<=0 and done[s]=1 in the same output clk.
  - If busy[s] and !buf_valid[s]: en=0, underrun[s]<=1, and the pointer does not advance (no nibble lost).
  - If !busy[s]: en=0.
- The slot counter wraps 3 -> 0. en is 0 on clocks without cen.
- Fetch engine (FSM IDLE -> REQ -> IDLE):
  - In IDLE, pick the next channel with busy & !buf_valid by round-robin, starting after the last granted channel.
  - Drive rom_addr, set rom_cs=1, go to REQ.
  - In REQ, hold rom_addr and rom_cs until rom_ok. On rom_ok: rom_cs<=0 and, if the tag is still valid, buf<=rom_data and buf_valid<=1. Return to IDLE.
  - Only one request is outstanding at a time. Minimum 2 clk between requests (request, ack).
- A byte written on rom_ok in the same clk as that channel's slot service is not visible until the next slot visit.

Decomposition:
- Package jt6295_pkg: NCH, AW, slot_t (2-bit), nib_ptr_t struct {addr, sel}, fetch FSM state enum.
- Sub-module jt6295_fetch_arb: round-robin requester, holds the outstanding tag and the discard flag, owns the ROM handshake.
- Top level: per-channel registers and slot service.

Test Plan:
- Single play, zero-latency ROM: ROM[0x100]=0x12, ROM[0x101]=0x34; start ch0, 0x100..0x101; cen every clk -> slot-0 en pulses carry 1,2,3,4. done[0] pulses with nibble 4, then busy[0]=0. Slots 1-3 have en=0.
- ROM stall: rom_ok delayed 12 clk per byte, cen every clk -> underrun[0]=1, en gaps, and nibble sequence 1,2,3,4 still complete and in order.
- Four channels concurrently, distinct ranges (2 bytes each) -> each slot's nibbles match its ROM content. Fetch grants rotate 0,1,2,3 with no starvation.
- Restart mid-play: start ch1 0x200..0x20F, then restart at 0x300 while a ch1 fetch is outstanding -> the 0x2xx byte is discarded and the next ch1 nibble comes from ROM[0x300] high.
- Stop and wrap: start ch2 0x3FFFF..0x00000 -> reads 0x3FFFF then 0x00000, done after 4 nibbles. Stop[2] mid-play instead -> busy[2]=0 with no done pulse.
- Reset mid-operation: rst_n low during REQ -> rom_cs=0, busy=0, en=0 immediately. After release, no stale rom_ok is accepted.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared types and constants for the ADPCM nibble fetcher.
// The slot counter and channel tags are 2 bits wide, so NCH is fixed at 4.
package jt6295_pkg;
    localparam int NCH = 4;
    localparam int AW  = 18;

    typedef logic [1:0] slot_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          sel;   // 0: high nibble next, 1: low nibble next
    } nib_ptr_t;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_REQ  = 1'b1
    } fetch_st_t;
endpackage

// File: rtl/jt6295_nibble_fetch_if.sv
// Shared ADPCM ROM byte port. rom_cs is the request (valid) and stays high
// until the one-clk rom_ok acknowledge; rom_data is only meaningful with rom_ok.
interface jt6295_nibble_fetch_if;
    import jt6295_pkg::*;

    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;

    modport master (output rom_addr, output rom_cs, input rom_data, input rom_ok);
    modport slave  (input rom_addr, input rom_cs, output rom_data, output rom_ok);
endinterface

// File: rtl/jt6295_fetch_arb.sv
// Round-robin ROM fetcher: one tagged request in flight; a kill on the tagged
// channel while the request is pending turns its result into a discard.
module jt6295_fetch_arb
    import jt6295_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          need,
    input  logic [NCH-1:0]          kill,
    input  logic [NCH-1:0][AW-1:0]  addr,
    jt6295_nibble_fetch_if.master   rom,
    output logic                    wr_en,
    output slot_t                   wr_ch,
    output logic [7:0]              wr_data,
    output fetch_st_t               state
);
    fetch_st_t     st_q;
    slot_t         tag_q;
    slot_t         last_q;
    logic          tag_ok_q;
    logic          cs_q;
    logic [AW-1:0] addr_q;

    slot_t pick;
    slot_t cand;
    logic  pick_ok;

    always_comb begin
        pick_ok = 1'b0;
        pick    = last_q;
        cand    = last_q;
        for (int i = 1; i <= NCH; i++) begin
            cand = last_q + slot_t'(i);
            if (!pick_ok && need[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= FS_IDLE;
            tag_q    <= '0;
            last_q   <= slot_t'(NCH - 1);
            tag_ok_q <= 1'b0;
            cs_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            case (st_q)
                FS_IDLE: begin
                    if (pick_ok) begin
                        st_q     <= FS_REQ;
                        tag_q    <= pick;
                        last_q   <= pick;
                        tag_ok_q <= !kill[pick];
                        addr_q   <= addr[pick];
                        cs_q     <= 1'b1;
                    end
                end
                FS_REQ: begin
                    if (kill[tag_q]) tag_ok_q <= 1'b0;
                    if (rom.rom_ok) begin
                        st_q     <= FS_IDLE;
                        cs_q     <= 1'b0;
                        tag_ok_q <= 1'b0;
                    end
                end
                default: st_q <= FS_IDLE;
            endcase
        end
    end

    assign rom.rom_addr = addr_q;
    assign rom.rom_cs   = cs_q;
    assign wr_en   = (st_q == FS_REQ) && rom.rom_ok && tag_ok_q && !kill[tag_q];
    assign wr_ch   = tag_q;
    assign wr_data = rom.rom_data;
    assign state   = st_q;
endmodule

// File: rtl/jt6295_nibble_fetch.sv
// Four-voice ADPCM nibble feeder: per-channel byte buffers filled from ROM,
// drained one nibble per cen slot into the decoder in slot order 0..3.
module jt6295_nibble_fetch
    import jt6295_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen,
    input  logic                  start,
    input  slot_t                 start_ch,
    input  logic [AW-1:0]         start_addr,
    input  logic [AW-1:0]         stop_addr,
    input  logic [NCH-1:0]        stop,
    jt6295_nibble_fetch_if.master rom,
    output logic [3:0]            data,
    output logic                  en,
    output slot_t                 slot,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        underrun,
    output fetch_st_t             fetch_st
);
    nib_ptr_t      ptr_q  [NCH];
    logic [AW-1:0] stop_q [NCH];
    logic [7:0]    buf_q  [NCH];
    logic [NCH-1:0] bufv_q, busy_q, underrun_q, done_q;
    slot_t         cnt_q, slot_q;
    logic [3:0]    data_q;
    logic          en_q;

    logic [NCH-1:0]         kill;
    logic [NCH-1:0][AW-1:0] ptr_addr;
    logic                   wr_en;
    slot_t                  wr_ch;
    logic [7:0]             wr_data;

    always_comb begin
        for (int i = 0; i < NCH; i++) ptr_addr[i] = ptr_q[i].addr;
    end

    assign kill = stop | (start ? (NCH'(1) << start_ch) : '0);

    jt6295_fetch_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .need    (busy_q & ~bufv_q),
        .kill    (kill),
        .addr    (ptr_addr),
        .rom     (rom),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .state   (fetch_st)
    );

    // Later assignments override earlier ones: service < ROM write < stop < start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                ptr_q[i]  <= '0;
                stop_q[i] <= '0;
                buf_q[i]  <= '0;
            end
            bufv_q     <= '0;
            busy_q     <= '0;
            underrun_q <= '0;
            done_q     <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            done_q <= '0;
            if (cen) begin
                cnt_q  <= cnt_q + 2'd1;
                slot_q <= cnt_q;
                if (busy_q[cnt_q]) begin
                    if (bufv_q[cnt_q]) begin
                        en_q   <= 1'b1;
                        data_q <= ptr_q[cnt_q].sel ? buf_q[cnt_q][3:0] : buf_q[cnt_q][7:4];
                        ptr_q[cnt_q].sel <= ~ptr_q[cnt_q].sel;
                        if (ptr_q[cnt_q].sel) begin
                            bufv_q[cnt_q]     <= 1'b0;
                            ptr_q[cnt_q].addr <= ptr_q[cnt_q].addr + AW'(1);
                            if (ptr_q[cnt_q].addr == stop_q[cnt_q]) begin
                                busy_q[cnt_q] <= 1'b0;
                                done_q[cnt_q] <= 1'b1;
                            end
                        end
                    end else begin
                        underrun_q[cnt_q] <= 1'b1;
                    end
                end
            end
            if (wr_en) begin
                buf_q[wr_ch]  <= wr_data;
                bufv_q[wr_ch] <= 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (stop[i]) begin
                    busy_q[i] <= 1'b0;
                    bufv_q[i] <= 1'b0;
                end
            end
            if (start) begin
                busy_q[start_ch]     <= 1'b1;
                bufv_q[start_ch]     <= 1'b0;
                underrun_q[start_ch] <= 1'b0;
                ptr_q[start_ch]      <= '{addr: start_addr, sel: 1'b0};
                stop_q[start_ch]     <= stop_addr;
            end
        end
    end

    assign data     = data_q;
    assign en       = en_q;
    assign slot     = slot_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;
endmodule
